// File: rtl/residual_add_relu.sv
// residual_add_relu: sequential saturating residual add with ReLU when RESIDUAL_ADD_RELU_EN is defined
module residual_add_relu #(
  parameter int BATCH_SIZE = 1,
  parameter int CHANNELS = 1,
  parameter int HEIGHT = 4,
  parameter int WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  localparam int N = BATCH_SIZE * CHANNELS * HEIGHT * WIDTH,
  localparam int NW = N * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] conv_tensor_flat,
  input  logic [NW-1:0] skip_tensor_flat,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] output_tensor_flat
);
  localparam int IDXW = N > 1 ? $clog2(N) : 1;
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [NW-1:0] conv_q, skip_q;
  logic [IDXW-1:0] idx;
  logic [DATA_WIDTH-1:0] a, b, sat, res;
  logic [DATA_WIDTH:0] sum;
  logic last;
  always_comb begin
    a = conv_q[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    b = skip_q[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    sat = sum[DATA_WIDTH] != sum[DATA_WIDTH-1] ? (sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX) : sum[DATA_WIDTH-1:0];
`ifdef RESIDUAL_ADD_RELU_EN
    res = sat[DATA_WIDTH-1] ? '0 : sat;
`else
    res = sat;
`endif
    last = idx == IDXW'(N - 1);
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      conv_q <= '0;
      skip_q <= '0;
      output_tensor_flat <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        conv_q <= conv_tensor_flat;
        skip_q <= skip_tensor_flat;
        output_tensor_flat <= '0;
        idx <= '0;
      end else if (state == RUN) begin
        output_tensor_flat[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= res;
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_residual_add_relu.sv
// tb_residual_add_relu: randomized self-checking bench; expectations follow RESIDUAL_ADD_RELU_EN
module tb_residual_add_relu;
  localparam int DW = 32;
  localparam int N = 16;
  logic clk = 0, rst = 0, start = 0;
  logic [N*DW-1:0] conv_f, skip_f, out_f;
  logic busy, done;
  logic [DW-1:0] conv_a[N], skip_a[N];
  logic [DW-1:0] cap_c[N], cap_s[N], exp_o[N];
  int errs = 0, checks = 0, dones = 0, cyc = 0, cnt = -1;
  int done_t[$];
  residual_add_relu #(.BATCH_SIZE(1), .CHANNELS(1), .HEIGHT(4), .WIDTH(4), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .conv_tensor_flat(conv_f), .skip_tensor_flat(skip_f),
    .busy(busy), .done(done), .output_tensor_flat(out_f)
  );
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign conv_f[g*DW +: DW] = conv_a[g];
    assign skip_f[g*DW +: DW] = skip_a[g];
  end
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] ref_elem(logic [DW-1:0] c, logic [DW-1:0] s);
    longint v = longint'($signed(c)) + longint'($signed(s));
    longint mx = (longint'(1) << (DW - 1)) - 1;
    longint mn = -(longint'(1) << (DW - 1));
    if (v > mx) v = mx;
    if (v < mn) v = mn;
`ifdef RESIDUAL_ADD_RELU_EN
    if (v < 0) v = 0;
`endif
    return v[DW-1:0];
  endfunction
  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      cnt = -1;
      for (int i = 0; i < N; i++) exp_o[i] = '0;
    end else if (cnt < 0) begin
      if (start) begin
        cnt = 0;
        for (int i = 0; i < N; i++) begin
          cap_c[i] = conv_a[i];
          cap_s[i] = skip_a[i];
          exp_o[i] = '0;
        end
      end
    end else if (cnt < N) begin
      exp_o[cnt] = ref_elem(cap_c[cnt], cap_s[cnt]);
      cnt++;
    end else cnt = -1;
  end
  always @(negedge clk) begin
    chk("busy", DW'(busy), DW'(cnt >= 0));
    chk("done", DW'(done), DW'(cnt == N));
    for (int i = 0; i < N; i++) chk($sformatf("out[%0d]", i), out_f[i*DW +: DW], exp_o[i]);
    if (done) begin
      dones++;
      done_t.push_back(cyc);
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_done();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    errs++;
    $display("FAIL done_timeout: got no done expected done within 40 cycles");
  endtask
  task automatic fill(logic [DW-1:0] c, logic [DW-1:0] s);
    for (int i = 0; i < N; i++) begin
      conv_a[i] = c;
      skip_a[i] = s;
    end
  endtask
  task automatic run();
    start = 1;
    tick();
    start = 0;
    wait_done();
    tick();
  endtask
  initial begin
    int d0;
    logic [DW-1:0] x;
    fill('0, '0);
    tick(2);
    chk("reset_busy", DW'(busy), '0);
    chk("reset_out0", out_f[DW-1:0], '0);
    rst = 1;
    tick();
    x = 32'd3;
    chk("pin_basic", ref_elem(32'd1, 32'd2), x);
`ifdef RESIDUAL_ADD_RELU_EN
    x = 32'h0;
`else
    x = 32'hFFFFFFFD;
`endif
    chk("pin_relu", ref_elem(32'hFFFFFFFB, 32'd2), x);
    x = 32'h7FFFFFFF;
    chk("pin_sat_pos", ref_elem(32'h7FFFFFF0, 32'h100), x);
`ifdef RESIDUAL_ADD_RELU_EN
    x = 32'h0;
`else
    x = 32'h80000000;
`endif
    chk("pin_sat_neg", ref_elem(32'h80000000, 32'hFFFFFFFF), x);
    for (int i = 0; i < N; i++) begin
      conv_a[i] = i;
      skip_a[i] = 2 * i;
    end
    d0 = dones;
    run();
    chk("basic_out5", out_f[5*DW +: DW], 32'd15);
    chk("basic_out15", out_f[15*DW +: DW], 32'd45);
    chk("basic_dones", DW'(dones - d0), 32'd1);
    fill(32'hFFFFFFFB, 32'd2);
    run();
    fill(32'h7FFFFFF0, 32'h100);
    run();
    chk("sat_pos_out0", out_f[DW-1:0], 32'h7FFFFFFF);
    fill(32'h80000000, 32'hFFFFFFFF);
    run();
    for (int i = 0; i < N; i++) begin
      conv_a[i] = $urandom;
      skip_a[i] = $urandom;
    end
    d0 = dones;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < N; i++) begin
      conv_a[i] = $urandom;
      skip_a[i] = $urandom;
    end
    tick(2);
    start = 1;
    tick();
    start = 0;
    tick(12);
    start = 1;
    tick();
    start = 0;
    tick(6);
    chk("ignored_start_dones", DW'(dones - d0), 32'd1);
    chk("ignored_start_busy", DW'(busy), '0);
    d0 = dones;
    start = 1;
    tick(40);
    start = 0;
    tick(20);
    chk("hold_dones", DW'(dones - d0), 32'd3);
    if (done_t.size() >= 2) chk("hold_period", DW'(done_t[$] - done_t[$-1]), 32'd18);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        conv_a[i] = ($urandom_range(3) == 0) ? {$urandom_range(1), {(DW-1){$urandom_range(1) == 1}}} : $urandom;
        skip_a[i] = ($urandom_range(3) == 0) ? {$urandom_range(1), {(DW-1){$urandom_range(1) == 1}}} : $urandom;
      end
      run();
    end
    start = 1;
    tick();
    start = 0;
    tick(5);
    rst = 0;
    tick(2);
    chk("midrun_busy", DW'(busy), '0);
    chk("midrun_done", DW'(done), '0);
    chk("midrun_out3", out_f[3*DW +: DW], '0);
    rst = 1;
    d0 = dones;
    tick(20);
    chk("post_reset_no_done", DW'(dones - d0), '0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
